// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch core: segment decode,
// per-digit modulus and counter width sizing.
package stopwatch_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bits needed to hold 0..max_val; never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned presc_width(input int unsigned tick_div);
        return cnt_width(tick_div - 1);
    endfunction

    function automatic int unsigned scan_width(input int unsigned scan_div);
        return cnt_width(scan_div - 1);
    endfunction

    function automatic int unsigned deb_width(input int unsigned cycles);
        return cnt_width(cycles - 1);
    endfunction

    // Digits 3 and 5 hold tens of seconds / tens of minutes.
    function automatic int unsigned mod_of(input int unsigned i);
        return (i == 3 || i == 5) ? 6 : 10;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button;
// emits a one-cycle pulse on each accepted press.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned DW = deb_width(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [DW-1:0] cnt_q,   cnt_d;

    // Counter runs only while the synced input disagrees with the stable level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/stopwatch_mux_core.sv
// N-digit BCD stopwatch with debounced start/stop and clear buttons and a
// multiplexed active-low 7-segment driver. Define LAP_EN for lap freeze.
module stopwatch_mux_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned N_DIGITS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SCAN_DIV        = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button0,
    input  logic                  button1,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  running,
    output logic [4*N_DIGITS-1:0] count_bcd
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW       = presc_width(TICK_DIV);
    localparam int unsigned SW       = scan_width(SCAN_DIV);
    localparam int unsigned IW       = cnt_width(N_DIGITS - 1);
    localparam int unsigned CW       = 4 * N_DIGITS;

    logic level0, level1, press0, press1;
    logic unused_levels;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (button0),
        .btn_level (level0),
        .btn_press (press0)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (button1),
        .btn_level (level1),
        .btn_press (press1)
    );

    assign unused_levels = level0 ^ level1;

    logic          running_q, running_d;
    logic [CW-1:0] count_q,   count_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [SW-1:0] scan_q,    scan_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic [6:0]    seg_q,     seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic          tick_c;
    logic          clear_c;
    logic [CW-1:0] disp_c;
    logic [CW-1:0] count_inc;
    logic [3:0]    digit_sel;

`ifdef LAP_EN
    logic [CW-1:0] lap_q, lap_d;
    logic          frozen_q, frozen_d;

    // Lap while running; any press1 while stopped drops the freeze.
    always_comb begin
        lap_d    = lap_q;
        frozen_d = frozen_q;
        if (press1) begin
            if (running_q) begin
                frozen_d = 1'b1;
                lap_d    = count_q;
            end else begin
                frozen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            lap_q    <= lap_d;
            frozen_q <= frozen_d;
        end
    end

    assign clear_c = press1 & ~running_q & ~frozen_q;
    assign disp_c  = frozen_q ? lap_q : count_q;
`else
    assign clear_c = press1;
    assign disp_c  = count_q;
`endif

    assign tick_c = running_q && (presc_q == PW'(TICK_DIV - 1));

    // Mixed-radix ripple increment of the whole count in one cycle.
    always_comb begin : p_inc
        logic carry;
        carry     = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'(mod_of(i) - 1)) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Clear overrides toggle; prescaler is parked at zero whenever stopped.
    always_comb begin
        running_d = running_q ^ press0;
        count_d   = tick_c ? count_inc : count_q;
        presc_d   = presc_q;
        if (running_q) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
        end
        if (clear_c) begin
            running_d = 1'b0;
            count_d   = '0;
        end
        if (!running_d) begin
            presc_d = '0;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) digit_sel = disp_c[4*i +: 4];
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        an_d  = ~(N_DIGITS'(1) << idx_q);
        seg_d = seg_decode(digit_sel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running_q <= 1'b0;
            count_q   <= '0;
            presc_q   <= '0;
            scan_q    <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
        end else begin
            running_q <= running_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign running   = running_q;
    assign count_bcd = count_q;

endmodule

// File: tb/tb_stopwatch_mux_core.sv
// Bench for stopwatch_mux_core at TICK_DIV=10, DEBOUNCE_CYCLES=4, SCAN_DIV=2;
// expected counts come from elapsed running cycles and mixed-radix arithmetic.
module tb_stopwatch_mux_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        button0 = 1'b0;
    logic        button1 = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        running;
    logic [15:0] count_bcd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ticks  = 0;
    int r_at   = 0;
    int f_at   = 0;

    stopwatch_mux_core #(
        .CLK_HZ(1000), .TICK_HZ(100), .N_DIGITS(4),
        .DEBOUNCE_CYCLES(4), .SCAN_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .button0(button0), .button1(button1),
        .seg(seg), .an(an), .running(running), .count_bcd(count_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int t);
        int v;
        int m;
        logic [15:0] r;
        v = t;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            m = (i == 3) ? 6 : 10;
            r[4*i +: 4] = 4'(v % m);
            v = v / m;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d < 10) ? t[d] : 7'h7F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic pulse1();
        button1 = 1'b1;
        repeat (10) step();
        button1 = 1'b0;
        repeat (12) step();
    endtask

    // Raise buttons and wait (bounded) for running to reach 'want'.
    task automatic press(input logic b0, input logic b1, input logic want, output int at);
        int t0;
        t0 = cyc;
        at = -1;
        button0 = b0;
        button1 = b1;
        for (int k = 0; k < 20 && at < 0; k++) begin
            step();
            if (running === want) at = cyc;
        end
        button0 = 1'b0;
        button1 = 1'b0;
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL press_timeout running=%b want=%b", running, want);
            at = cyc;
        end else if (at - t0 < 6 || at - t0 > 8) begin
            errors++;
            $display("FAIL press_latency got %0d cycles want 6..8", at - t0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want f", an); end
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", count_bcd); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        rst = 1'b1;
        repeat (3) step();
        ticks = 0;
    endtask

    task automatic test_debounce();
        int t0;
        int rise;
        logic seen_high;
        logic fell;
        seen_high = 1'b0;
        button0 = 1'b1;
        repeat (3) step();
        button0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (running !== 1'b0) seen_high = 1'b1;
        end
        checks++; if (seen_high) begin errors++; $display("FAIL debounce_glitch running rose=%b want 0", seen_high); end
        t0 = cyc;
        rise = -1;
        fell = 1'b0;
        button0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rise < 0 && running === 1'b1) rise = cyc;
        end
        button0 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (rise < 0 && running === 1'b1) rise = cyc;
            else if (rise >= 0 && running !== 1'b1) fell = 1'b1;
        end
        checks++;
        if (rise < 0 || rise - t0 < 6 || rise - t0 > 8) begin
            errors++;
            $display("FAIL debounce_latency got %0d want 6..8", (rise < 0) ? -1 : rise - t0);
        end
        checks++; if (fell) begin errors++; $display("FAIL debounce_single running fell=%b want 0", fell); end
        r_at = (rise < 0) ? cyc : rise;
    endtask

    task automatic test_count();
        wait_to(r_at + 1000);
        checks++; if (count_bcd !== 16'h0100) begin errors++; $display("FAIL count_100 got %h want 0100", count_bcd); end
        wait_to(r_at + 59990);
        checks++; if (count_bcd !== 16'h5999) begin errors++; $display("FAIL count_5999 got %h want 5999", count_bcd); end
        wait_to(r_at + 60000);
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL count_wrap got %h want 0000", count_bcd); end
        wait_to(r_at + 60010);
        checks++; if (count_bcd !== 16'h0001 || running !== 1'b1) begin
            errors++; $display("FAIL count_after_wrap got %h/%b want 0001/1", count_bcd, running);
        end
    endtask

    task automatic test_scan(input logic [15:0] exp);
        int idx;
        int prev;
        int run;
        logic seen_change;
        prev = -1;
        run = 0;
        seen_change = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            idx = -1;
            for (int i = 0; i < 4; i++) if (an === ~(4'b0001 << i)) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("FAIL scan_an got %h want one-hot-low", an);
            end else begin
                checks++;
                if (seg !== seg_of(exp[4*idx +: 4])) begin
                    errors++; $display("FAIL scan_seg idx %0d got %h want %h", idx, seg, seg_of(exp[4*idx +: 4]));
                end
                if (prev >= 0 && idx != prev) begin
                    checks++;
                    if (idx != (prev + 1) % 4 || (seen_change && run != 2)) begin
                        errors++; $display("FAIL scan_order idx %0d after %0d held %0d want next after 2", idx, prev, run);
                    end
                    seen_change = 1'b1;
                    run = 1;
                end else begin
                    run++;
                end
                prev = idx;
            end
        end
    endtask

    task automatic test_stop_resume();
        logic [15:0] exp;
        for (int it = 0; it < 3; it++) begin
            wait_to(cyc + int'($urandom_range(30, 300)));
            press(1'b1, 1'b0, 1'b0, f_at);
            ticks += (f_at - r_at) / 10;
            exp = to_bcd(ticks);
            checks++; if (count_bcd !== exp) begin errors++; $display("FAIL stop_count got %h want %h", count_bcd, exp); end
            repeat (50) step();
            checks++; if (count_bcd !== exp || running !== 1'b0) begin
                errors++; $display("FAIL stop_hold got %h/%b want %h/0", count_bcd, running, exp);
            end
            test_scan(exp);
            press(1'b1, 1'b0, 1'b1, r_at);
            wait_to(r_at + 9);
            checks++; if (count_bcd !== exp) begin errors++; $display("FAIL resume_early got %h want %h", count_bcd, exp); end
            wait_to(r_at + 10);
            checks++; if (count_bcd !== to_bcd(ticks + 1)) begin
                errors++; $display("FAIL resume_first got %h want %h", count_bcd, to_bcd(ticks + 1));
            end
        end
    endtask

`ifndef LAP_EN
    task automatic test_simultaneous();
        wait_to(cyc + int'($urandom_range(20, 200)));
        press(1'b1, 1'b1, 1'b0, f_at);
        ticks = 0;
        checks++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL simul_clear got %h/%b want 0000/0", count_bcd, running);
        end
        repeat (12) step();
        press(1'b1, 1'b0, 1'b1, r_at);
        wait_to(r_at + int'($urandom_range(40, 400)));
        press(1'b1, 1'b0, 1'b0, f_at);
        ticks = (f_at - r_at) / 10;
        checks++; if (count_bcd !== to_bcd(ticks)) begin
            errors++; $display("FAIL restart_count got %h want %h", count_bcd, to_bcd(ticks));
        end
        repeat (12) step();
        pulse1();
        ticks = 0;
        checks++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL stopped_clear got %h/%b want 0000/0", count_bcd, running);
        end
    endtask
`else
    task automatic test_lap();
        press(1'b1, 1'b0, 1'b0, f_at);
        repeat (12) step();
        pulse1();
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL lap_preclear got %h want 0000", count_bcd); end
        press(1'b1, 1'b0, 1'b1, r_at);
        wait_to(r_at + 501);
        button1 = 1'b1;
        repeat (10) step();
        button1 = 1'b0;
        wait_to(r_at + 700);
        checks++; if (count_bcd !== to_bcd(70)) begin errors++; $display("FAIL lap_live got %h want %h", count_bcd, to_bcd(70)); end
        test_scan(to_bcd(50));
        checks++; if (count_bcd !== to_bcd((cyc - r_at) / 10)) begin
            errors++; $display("FAIL lap_live2 got %h want %h", count_bcd, to_bcd((cyc - r_at) / 10));
        end
        press(1'b1, 1'b0, 1'b0, f_at);
        ticks = (f_at - r_at) / 10;
        repeat (12) step();
        test_scan(to_bcd(50));
        pulse1();
        test_scan(to_bcd(ticks));
        checks++; if (count_bcd !== to_bcd(ticks)) begin errors++; $display("FAIL lap_unfreeze got %h want %h", count_bcd, to_bcd(ticks)); end
        pulse1();
        ticks = 0;
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL lap_clear got %h want 0000", count_bcd); end
    endtask
`endif

    task automatic test_async_reset();
        press(1'b1, 1'b0, 1'b1, r_at);
        repeat (int'($urandom_range(20, 60))) step();
        #3;
        rst = 1'b0;
        #1;
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg got %h want 7f", seg); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL async_an got %h want f", an); end
        checks++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL async_state got %h/%b want 0000/0", count_bcd, running);
        end
        repeat (3) step();
        rst = 1'b1;
        ticks = 0;
        repeat (3) step();
        checks++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL post_reset got %h/%b want 0000/0", count_bcd, running);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_count();
        test_stop_resume();
`ifndef LAP_EN
        test_simultaneous();
`else
        test_lap();
`endif
        repeat (12) step();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
